// File: rtl/spi_tx_if.sv
// -----------------------------------------------------------------------------
// spi_tx_if -- bundle of the load handshake and outbound serial lines of spi_tx.
//
// Signals:
//   data_in       word to send, sampled only on an accepted trigger
//   trigger_in    one-cycle start request from game logic
//   data_out      serial data line (MOSI), MSB first
//   data_clk_out  serial clock, idles low, receiver samples on rising edge
//   sel_out       active-low frame select
//   busy_out      transmitter is occupied and ignores triggers
//   done_out      one-cycle pulse at the end of the last bit
//
// Modports:
//   master  game-logic side: drives data_in/trigger_in, observes the rest
//   slave   transmitter side (spi_tx)
// -----------------------------------------------------------------------------
interface spi_tx_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] data_in;
    logic                  trigger_in;
    logic                  data_out;
    logic                  data_clk_out;
    logic                  sel_out;
    logic                  busy_out;
    logic                  done_out;

    modport master (
        output data_in, trigger_in,
        input  data_out, data_clk_out, sel_out, busy_out, done_out
    );

    modport slave (
        input  data_in, trigger_in,
        output data_out, data_clk_out, sel_out, busy_out, done_out
    );
endinterface

// File: rtl/spi_tx.sv
// -----------------------------------------------------------------------------
// spi_tx -- SPI-style serial transmitter carrying one local word to the
// opponent board. Peer of spi_rx: data_clk idles low, data changes on the
// falling edge, receiver samples on the rising edge, MSB first, one word per
// active-low select frame, followed by a HALF-cycle gap with select high.
//
// Parameters:
//   DATA_WIDTH       bits per word (must match the receiving spi_rx)
//   DATA_CLK_PERIOD  data_clk_out period in clk_in cycles, even and >= 2
//
// Ports:
//   clk_in  system clock
//   rst_in  synchronous active-high reset
//   bus     spi_tx_if.slave: data_in, trigger_in in;
//           data_out, data_clk_out, sel_out, busy_out, done_out out
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module spi_tx #(
    parameter int DATA_WIDTH      = 16,
    parameter int DATA_CLK_PERIOD = 8
) (
    input  logic     clk_in,
    input  logic     rst_in,
    spi_tx_if.slave  bus
);
    localparam int HALF = DATA_CLK_PERIOD / 2;
    localparam int HC_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int BC_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    if ((DATA_CLK_PERIOD < 2) || (DATA_CLK_PERIOD % 2 != 0)) begin : g_bad_period
        $error("spi_tx: DATA_CLK_PERIOD must be even and >= 2");
    end

    // LOAD is the single cycle between accepting a trigger and opening the
    // frame, so sel/data/busy change one edge after the trigger is sampled.
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        TRANSMIT,
        GAP
    } state_t;

    state_t                state,      state_next;
    logic [DATA_WIDTH-1:0] shift,      shift_next;
    logic [BC_W-1:0]       bit_count,  bit_count_next;
    logic [HC_W-1:0]       half_count, half_count_next;
    logic                  data_q,     data_next;
    logic                  dclk_q,     dclk_next;
    logic                  sel_q,      sel_next;
    logic                  busy_q,     busy_next;
    logic                  done_q,     done_next;

    logic half_wrap;
    assign half_wrap = (half_count == HC_W'(HALF - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of order.
    // The shift register is reset too; it is small and keeps the state fully
    // defined after reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            shift      <= '0;
            bit_count  <= '0;
            half_count <= '0;
            data_q     <= 1'b0;
            dclk_q     <= 1'b0;
            sel_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_next;
            shift      <= shift_next;
            bit_count  <= bit_count_next;
            half_count <= half_count_next;
            data_q     <= data_next;
            dclk_q     <= dclk_next;
            sel_q      <= sel_next;
            busy_q     <= busy_next;
            done_q     <= done_next;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case statement, so
        // no path leaves one unassigned and no latch is inferred.
        state_next      = state;
        shift_next      = shift;
        bit_count_next  = bit_count;
        half_count_next = half_count;
        data_next       = data_q;
        dclk_next       = dclk_q;
        sel_next        = sel_q;
        busy_next       = busy_q;
        done_next       = 1'b0;

        case (state)
            IDLE: begin
                if (bus.trigger_in) begin
                    shift_next      = bus.data_in;
                    bit_count_next  = '0;
                    half_count_next = '0;
                    state_next      = LOAD;
                end
            end

            LOAD: begin
                sel_next   = 1'b0;
                data_next  = shift[DATA_WIDTH-1];
                busy_next  = 1'b1;
                state_next = TRANSMIT;
            end

            TRANSMIT: begin
                if (half_wrap) begin
                    half_count_next = '0;
                    if (!dclk_q) begin
                        dclk_next = 1'b1;
                    end else begin
                        dclk_next = 1'b0;
                        if (bit_count == BC_W'(DATA_WIDTH - 1)) begin
                            // Last falling edge closes the frame in the same cycle.
                            sel_next   = 1'b1;
                            data_next  = 1'b0;
                            done_next  = 1'b1;
                            state_next = GAP;
                        end else begin
                            shift_next     = shift << 1;
                            data_next      = shift_next[DATA_WIDTH-1];
                            bit_count_next = bit_count + BC_W'(1);
                        end
                    end
                end else begin
                    half_count_next = half_count + HC_W'(1);
                end
            end

            GAP: begin
                if (half_wrap) begin
                    half_count_next = '0;
                    busy_next       = 1'b0;
                    state_next      = IDLE;
                end else begin
                    half_count_next = half_count + HC_W'(1);
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign bus.data_out     = data_q;
    assign bus.data_clk_out = dclk_q;
    assign bus.sel_out      = sel_q;
    assign bus.busy_out     = busy_q;
    assign bus.done_out     = done_q;
endmodule

// File: tb/tb_spi_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_tx -- directed bench for spi_tx. Two instances: a (period 8) and
// b (period 2). A small receiver model on instance a collects complete words.
// Inputs change on the falling clock edge; outputs are read there too. "t"
// counts rising edges after the edge that samples the trigger (t = 0).
// -----------------------------------------------------------------------------
module tb_spi_tx;
    logic clk = 1'b0;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spi_tx_if #(.DATA_WIDTH(16)) a_if ();
    spi_tx_if #(.DATA_WIDTH(16)) b_if ();

    spi_tx #(.DATA_WIDTH(16), .DATA_CLK_PERIOD(8)) dut_a (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (a_if)
    );

    spi_tx #(.DATA_WIDTH(16), .DATA_CLK_PERIOD(2)) dut_b (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (b_if)
    );

    // Receiver model: sample on data_clk rising edge while selected, keep the
    // word only if a full 16 bits arrived before select went high.
    logic [15:0] rx_shift = '0;
    int          rx_bits  = 0;
    logic [15:0] rx_q[$];

    always @(posedge a_if.data_clk_out) begin
        if (a_if.sel_out === 1'b0) begin
            rx_shift = {rx_shift[14:0], a_if.data_out};
            rx_bits  = rx_bits + 1;
        end
    end

    always @(posedge a_if.sel_out) begin
        if (rx_bits == 16) rx_q.push_back(rx_shift);
        rx_bits = 0;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full frame on instance a, trigger sampled at t = 0. With glitch set,
    // data_in changes after accept and triggers hit cycles 10 and 129.
    task automatic frame(input logic [15:0] word, input bit glitch);
        int          sel_err = 0, dclk_err = 0, data_err = 0;
        int          done_err = 0, busy_err = 0, n_rise = 0;
        logic [15:0] sampled = '0;
        logic        prev_dclk;

        a_if.data_in    = word;
        a_if.trigger_in = 1'b1;
        tick();
        a_if.trigger_in = 1'b0;
        check("accept_sel", a_if.sel_out, 1);
        check("accept_busy", a_if.busy_out, 0);
        prev_dclk = a_if.data_clk_out;

        for (int t = 1; t <= 140; t++) begin
            bit in_frame;
            int idx;
            tick();
            in_frame = (t >= 1) && (t <= 128);
            idx      = (t - 1) / 8;
            if (a_if.sel_out !== !in_frame) sel_err++;
            if (a_if.data_clk_out !== (in_frame && ((t - 1) % 8 >= 4))) dclk_err++;
            if (a_if.data_out !== (in_frame ? word[15-idx] : 1'b0)) data_err++;
            if (a_if.done_out !== (t == 129)) done_err++;
            if (a_if.busy_out !== (t <= 132)) busy_err++;
            if (a_if.data_clk_out === 1'b1 && prev_dclk === 1'b0) begin
                n_rise++;
                sampled = {sampled[14:0], a_if.data_out};
                if (a_if.sel_out !== 1'b0) sel_err++;
            end
            prev_dclk = a_if.data_clk_out;
            if (glitch) begin
                if (t == 1)   a_if.data_in    = 16'h1234;
                if (t == 9)   a_if.trigger_in = 1'b1;
                if (t == 10)  a_if.trigger_in = 1'b0;
                if (t == 128) a_if.trigger_in = 1'b1;
                if (t == 129) a_if.trigger_in = 1'b0;
            end
        end

        check("frame_sel_window", sel_err, 0);
        check("frame_dclk_wave", dclk_err, 0);
        check("frame_data_bits", data_err, 0);
        check("frame_done_pulse", done_err, 0);
        check("frame_busy_window", busy_err, 0);
        check("frame_rise_count", n_rise, 16);
        check("frame_sampled_word", sampled, word);
    endtask

    initial begin
        int sel_fall[$];
        int t;
        int err;
        logic prev_sel;

        // Reset
        rst = 1'b1;
        a_if.data_in = '0; a_if.trigger_in = 1'b0;
        b_if.data_in = '0; b_if.trigger_in = 1'b0;
        repeat (3) tick();
        check("rst_sel", a_if.sel_out, 1);
        check("rst_dclk", a_if.data_clk_out, 0);
        check("rst_data", a_if.data_out, 0);
        check("rst_busy", a_if.busy_out, 0);
        check("rst_done", a_if.done_out, 0);
        rst = 1'b0;
        repeat (2) tick();

        // Single word with ignored triggers and data_in change mid-flight
        rx_q.delete();
        frame(16'hA5C3, 1'b1);
        check("glitch_rx_count", rx_q.size(), 1);
        check("glitch_rx_word", (rx_q.size() > 0) ? rx_q[0] : 16'hxxxx, 16'hA5C3);

        // Back-to-back with trigger held high: 0001 then FFFF
        repeat (3) tick();
        rx_q.delete();
        a_if.data_in    = 16'h0001;
        a_if.trigger_in = 1'b1;
        tick();
        a_if.data_in = 16'hFFFF;
        prev_sel = a_if.sel_out;
        t = 0;
        while (rx_q.size() < 2 && t < 400) begin
            tick();
            t++;
            if (prev_sel === 1'b1 && a_if.sel_out === 1'b0) sel_fall.push_back(t);
            prev_sel = a_if.sel_out;
        end
        a_if.trigger_in = 1'b0;
        check("b2b_timeout", rx_q.size(), 2);
        check("b2b_fall0", (sel_fall.size() > 0) ? sel_fall[0] : -1, 1);
        check("b2b_fall1", (sel_fall.size() > 1) ? sel_fall[1] : -1, 135);
        check("b2b_word0", (rx_q.size() > 0) ? rx_q[0] : 16'hxxxx, 16'h0001);
        check("b2b_word1", (rx_q.size() > 1) ? rx_q[1] : 16'hxxxx, 16'hFFFF);
        repeat (10) tick();
        check("b2b_no_third_sel", a_if.sel_out, 1);
        check("b2b_no_third_busy", a_if.busy_out, 0);

        // Reset mid-transfer, then a fresh word at cycle 70
        rx_q.delete();
        a_if.data_in    = 16'hA5C3;
        a_if.trigger_in = 1'b1;
        tick();
        a_if.trigger_in = 1'b0;
        for (int i = 1; i <= 60; i++) tick();
        rst = 1'b1;
        tick();
        check("midrst_sel", a_if.sel_out, 1);
        check("midrst_dclk", a_if.data_clk_out, 0);
        check("midrst_busy", a_if.busy_out, 0);
        check("midrst_data", a_if.data_out, 0);
        rst = 1'b0;
        err = (a_if.done_out !== 1'b0) ? 1 : 0;
        for (int i = 62; i <= 69; i++) begin
            tick();
            if (a_if.done_out !== 1'b0) err++;
        end
        check("midrst_no_done", err, 0);
        frame(16'h3C96, 1'b0);
        check("midrst_rx_count", rx_q.size(), 1);
        check("midrst_rx_word", (rx_q.size() > 0) ? rx_q[0] : 16'hxxxx, 16'h3C96);

        // Fastest data clock on instance b: 8000
        begin
            int b_sel = 0, b_dclk = 0, b_data = 0, b_done = 0, b_busy = 0;
            b_if.data_in    = 16'h8000;
            b_if.trigger_in = 1'b1;
            tick();
            b_if.trigger_in = 1'b0;
            for (int k = 1; k <= 40; k++) begin
                tick();
                if (b_if.sel_out !== !(k >= 1 && k <= 32)) b_sel++;
                if (b_if.data_clk_out !== (k >= 2 && k <= 32 && k % 2 == 0)) b_dclk++;
                if (b_if.data_out !== (k == 1 || k == 2)) b_data++;
                if (b_if.done_out !== (k == 33)) b_done++;
                if (b_if.busy_out !== (k <= 33)) b_busy++;
            end
            check("p2_sel_window", b_sel, 0);
            check("p2_dclk_toggle", b_dclk, 0);
            check("p2_data_msb", b_data, 0);
            check("p2_done_33", b_done, 0);
            check("p2_busy_window", b_busy, 0);
        end

        // Idle lines for 1000 cycles
        err = 0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (a_if.sel_out !== 1'b1 || a_if.data_clk_out !== 1'b0 || a_if.data_out !== 1'b0) err++;
        end
        check("idle_lines", err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
